// File: rtl/projectile_motion_ctl_if.sv
// Launch/position bus between game logic and the projectile motion controller.
// Optional macro WIND_EN adds the signed wind input.
interface projectile_motion_ctl_if;
  logic               frame_tick;
  logic               launch;
  logic signed [11:0] x_start;
  logic signed [9:0]  vx_init;
  logic signed [9:0]  vy_init;
`ifdef WIND_EN
  logic signed [5:0]  wind;
`endif
  logic signed [11:0] x_pos;
  logic        [11:0] y_pos;
  logic               active;
  logic               in_flight;
  logic               landed;
  logic               busy_out;

  modport master (
`ifdef WIND_EN
    output wind,
`endif
    output frame_tick, launch, x_start, vx_init, vy_init,
    input  x_pos, y_pos, active, in_flight, landed, busy_out
  );

  modport slave (
`ifdef WIND_EN
    input  wind,
`endif
    input  frame_tick, launch, x_start, vx_init, vy_init,
    output x_pos, y_pos, active, in_flight, landed, busy_out
  );
endinterface

// File: rtl/projectile_motion_ctl.sv
// Frame-by-frame fixed-point ballistic trajectory generator for the overlay stage.
// X 0 = screen centre (signed, positive right), Y 0 = ground (positive up).
// Optional macro WIND_EN: wind accelerates vx on every flight frame.
module projectile_motion_ctl #(
  parameter int FRAC        = 4,
  parameter int GRAVITY     = 2,
  parameter int X_LIMIT     = 512,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  projectile_motion_ctl_if.slave bus
);

  localparam int ACC_W = 12 + FRAC;
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [ACC_W-1:0] GRAV        = ACC_W'(GRAVITY);
  localparam logic signed [ACC_W-1:0] X_LIM_POS   = ACC_W'(X_LIMIT);
  localparam logic signed [ACC_W-1:0] X_LIM_NEG   = ACC_W'(-X_LIMIT);
  localparam logic signed [ACC_W-1:0] X_CLAMP_POS = ACC_W'(X_LIMIT * (2 ** FRAC));
  localparam logic signed [ACC_W-1:0] X_CLAMP_NEG = ACC_W'(-(X_LIMIT * (2 ** FRAC)));

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    LANDED
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] xAcc_q, xAcc_d;
  logic signed [ACC_W-1:0] yAcc_q, yAcc_d;
  logic signed [ACC_W-1:0] vx_q, vx_d;
  logic signed [ACC_W-1:0] vy_q, vy_d;
  logic [CNT_W-1:0]        holdCnt_q, holdCnt_d;
  logic [11:0]             xPos_q, yPos_q;
  logic                    landed_q, landed_d;

  logic signed [ACC_W-1:0] xNext, yNext, xWhole;

  // Next-state, integration step and landing/bounds decisions
  always_comb begin
    state_d   = state_q;
    xAcc_d    = xAcc_q;
    yAcc_d    = yAcc_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    holdCnt_d = holdCnt_q;
    landed_d  = 1'b0;
    xNext     = xAcc_q + vx_q;
    yNext     = yAcc_q + vy_q;
    xWhole    = xNext >>> FRAC;

    case (state_q)
      IDLE: begin
        if (bus.launch) begin
          xAcc_d  = {bus.x_start, {FRAC{1'b0}}};
          yAcc_d  = '0;
          vx_d    = {{(ACC_W-10){bus.vx_init[9]}}, bus.vx_init};
          vy_d    = {{(ACC_W-10){bus.vy_init[9]}}, bus.vy_init};
          state_d = FLIGHT;
        end
      end

      FLIGHT: begin
        if (bus.frame_tick) begin
          vy_d = vy_q - GRAV;
`ifdef WIND_EN
          vx_d = vx_q + {{(ACC_W-6){bus.wind[5]}}, bus.wind};
`endif
          if (yNext[ACC_W-1] || (yNext == '0)) begin
            xAcc_d    = xNext;
            yAcc_d    = '0;
            holdCnt_d = CNT_W'(HOLD_FRAMES);
            landed_d  = 1'b1;
            state_d   = LANDED;
          end else if ((xWhole > X_LIM_POS) || (xWhole < X_LIM_NEG)) begin
            xAcc_d    = xNext[ACC_W-1] ? X_CLAMP_NEG : X_CLAMP_POS;
            yAcc_d    = yNext;
            holdCnt_d = CNT_W'(HOLD_FRAMES);
            landed_d  = 1'b1;
            state_d   = LANDED;
          end else begin
            xAcc_d = xNext;
            yAcc_d = yNext;
          end
        end
      end

      LANDED: begin
        if (bus.frame_tick) begin
          if (holdCnt_q <= CNT_W'(1)) begin
            holdCnt_d = '0;
            xAcc_d    = '0;
            yAcc_d    = '0;
            vx_d      = '0;
            vy_d      = '0;
            state_d   = IDLE;
          end else begin
            holdCnt_d = holdCnt_q - CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, accumulators and registered pixel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xAcc_q    <= '0;
      yAcc_q    <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      holdCnt_q <= '0;
      xPos_q    <= '0;
      yPos_q    <= '0;
      landed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      xAcc_q    <= xAcc_d;
      yAcc_q    <= yAcc_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      holdCnt_q <= holdCnt_d;
      xPos_q    <= xAcc_d[ACC_W-1:FRAC];
      yPos_q    <= yAcc_d[ACC_W-1:FRAC];
      landed_q  <= landed_d;
    end
  end

  assign bus.x_pos     = xPos_q;
  assign bus.y_pos     = yPos_q;
  assign bus.active    = (state_q != IDLE);
  assign bus.in_flight = (state_q == FLIGHT);
  assign bus.landed    = landed_q;
  assign bus.busy_out  = (state_q != IDLE);

endmodule
